// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network layer datapath blocks.
package nn_pkg;

  localparam int DEFAULT_RESOLUTION = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT,
    STORE,
    DONE
  } layer_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum and its index across one layer pass.
// Only built when LAYER_CTRL_ARGMAX_EN is defined.
`ifdef LAYER_CTRL_ARGMAX_EN
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int RESOLUTION = DEFAULT_RESOLUTION
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         valid,
  input  logic [IDX_W-1:0]             idx,
  input  logic signed [RESOLUTION-1:0] value,
  output logic [IDX_W-1:0]             best_idx
);

  logic signed [RESOLUTION-1:0] max_q, max_d;
  logic [IDX_W-1:0]             best_q, best_d;

  // Strictly-greater compare keeps the lower index on ties.
  always_comb begin
    max_d  = max_q;
    best_d = best_q;
    if (valid && (clear || (value > max_q))) begin
      max_d  = value;
      best_d = idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q  <= '0;
      best_q <= '0;
    end else begin
      max_q  <= max_d;
      best_q <= best_d;
    end
  end

  assign best_idx = best_q;

endmodule
`endif

// File: rtl/layer_controller.sv
// Sequences one shared neuron across all outputs of a fully connected layer.
// Define LAYER_CTRL_ARGMAX_EN to build the argmax tracker; otherwise argmax is 0.
module layer_controller
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS    = 10,
  parameter int RESOLUTION     = DEFAULT_RESOLUTION,
  parameter int NEURON_LATENCY = 4,
  parameter int IDX_W          = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [IDX_W-1:0]                  rom_addr,
  output logic                              neuron_go,
  input  logic signed [RESOLUTION-1:0]      neuron_out,
  output logic [NUM_NEURONS*RESOLUTION-1:0] results,
  output logic [IDX_W-1:0]                  argmax
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | rom_addr presented, synchronous ROM read in flight
  // FIRE  | neuron_go pulse, wait counter cleared
  // WAIT  | neuron computing, count 0..NEURON_LATENCY-1
  // STORE | capture neuron_out into results slot idx
  // DONE  | one-cycle done pulse

  localparam int CNT_W = (NEURON_LATENCY > 1) ? $clog2(NEURON_LATENCY) : 1;

  layer_state_t                      state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_NEURONS*RESOLUTION-1:0] results_q, results_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    results_d = results_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD:  state_d = FIRE;
      FIRE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(NEURON_LATENCY - 1)) state_d = STORE;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      STORE: begin
        results_d[int'(idx_q)*RESOLUTION +: RESOLUTION] = neuron_out;
        // Last-index check precedes the increment so idx never wraps.
        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      results_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      results_q <= results_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign neuron_go = (state_q == FIRE);
  assign rom_addr  = idx_q;
  assign results   = results_q;

`ifdef LAYER_CTRL_ARGMAX_EN
  // Neuron 0 seeds the running maximum on every pass.
  argmax_tracker #(
    .IDX_W      (IDX_W),
    .RESOLUTION (RESOLUTION)
  ) u_argmax (
    .clk      (clk),
    .reset    (reset),
    .clear    (idx_q == '0),
    .valid    (state_q == STORE),
    .idx      (idx_q),
    .value    (neuron_out),
    .best_idx (argmax)
  );
`else
  assign argmax = '0;
`endif

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller with a behavioural neuron and a done-scoreboard.
module tb_layer_controller;
  import nn_pkg::*;

  localparam int N  = 4;
  localparam int L  = 5;
  localparam int R  = 8;
  localparam int IW = 2;
  localparam int PASS_CYC = N * (L + 3) + 1;
`ifdef LAYER_CTRL_ARGMAX_EN
  localparam bit AM_EN = 1'b1;
`else
  localparam bit AM_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, neuron_go;
  logic [IW-1:0]  rom_addr, argmax;
  logic [R-1:0]   neuron_out = '0;
  logic [N*R-1:0] results;

  layer_controller #(
    .NUM_NEURONS    (N),
    .RESOLUTION     (R),
    .NEURON_LATENCY (L),
    .IDX_W          (IW)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .neuron_go  (neuron_go),
    .neuron_out (neuron_out),
    .results    (results),
    .argmax     (argmax)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*R-1:0] res;
    logic [IW-1:0]  am;
    int             dcyc;
  } sb_t;

  sb_t exp_q[$];
  sb_t obs_q[$];
  int  exp_go[$];
  int  go_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  go_in_done = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  logic signed [R-1:0] tbl [N];
  logic signed [R-1:0] nval = '0;
  int                  ncnt = 0;

  // Behavioural neuron: table value for rom_addr, valid L cycles after neuron_go.
  always @(posedge clk) begin
    if (neuron_go) begin
      ncnt       <= L - 1;
      nval       <= tbl[rom_addr];
      neuron_out <= 8'hAA;
    end else if (ncnt != 0) begin
      ncnt <= ncnt - 1;
      if (ncnt == 1) neuron_out <= nval;
    end
  end

  // cyc is the number of the edge that ends the cycle being observed.
  always @(posedge clk) begin
    sb_t o;
    cyc = cyc + 1;
    if (neuron_go) go_q.push_back(cyc);
    if (neuron_go && done) go_in_done++;
    if (done) begin
      o.res  = results;
      o.am   = argmax;
      o.dcyc = cyc;
      obs_q.push_back(o);
      done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tbl(input int a, input int b, input int c, input int d);
    tbl[0] = 8'(a);
    tbl[1] = 8'(b);
    tbl[2] = 8'(c);
    tbl[3] = 8'(d);
  endtask

  task automatic push_pass(input int acc);
    sb_t                 e;
    logic signed [R-1:0] best;
    int                  bi;
    e.res = '0;
    best  = tbl[0];
    bi    = 0;
    for (int i = 0; i < N; i++) begin
      e.res[i*R +: R] = tbl[i];
      if (i > 0 && tbl[i] > best) begin
        best = tbl[i];
        bi   = i;
      end
      exp_go.push_back(acc + 2 + i * (L + 3));
    end
    e.am   = AM_EN ? IW'(bi) : '0;
    e.dcyc = acc + PASS_CYC;
    exp_q.push_back(e);
  endtask

  task automatic start_pass(input bit expect_done, output int acc);
    @(negedge clk);
    start = 1'b1;
    acc   = cyc + 1;
    if (expect_done) push_pass(acc);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", obs_q.size() >= n, 1);
  endtask

  task automatic compare_all();
    sb_t e, o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("results", o.res, e.res);
      check("argmax", o.am, e.am);
      check("done_cycle", o.dcyc, e.dcyc);
    end
    check("sb_leftover", exp_q.size() + obs_q.size(), 0);
    check("go_count", go_q.size(), exp_go.size());
    while (go_q.size() > 0 && exp_go.size() > 0)
      check("go_cycle", go_q.pop_front(), exp_go.pop_front());
    exp_q.delete();
    obs_q.delete();
    exp_go.delete();
    go_q.delete();
  endtask

  task automatic run_pass();
    int acc;
    start_pass(1'b1, acc);
    wait_done(1);
    check("busy_after_done", busy, 0);
    compare_all();
  endtask

  initial begin
    int acc;
    int d0;

    set_tbl(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_go", neuron_go, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_argmax", argmax, 0);
    check("rst_results", results, 0);
    rst_n = 1'b1;

    set_tbl(3, -7, 20, 5);
    run_pass();
    check("basic_results_lit", results, 32'h0514F903);
    check("basic_argmax_lit", argmax, AM_EN ? 2 : 0);

    set_tbl(-2, -1, -1, -9);
    run_pass();
    check("neg_tie_argmax_lit", argmax, AM_EN ? 1 : 0);

    set_tbl(9, 9, 9, 9);
    run_pass();
    check("all_equal_argmax_lit", argmax, 0);

    // start held across two passes
    set_tbl(3, -7, 20, 5);
    @(negedge clk);
    start = 1'b1;
    acc   = cyc + 1;
    push_pass(acc);
    push_pass(acc + PASS_CYC + 1);
    wait_done(1);
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    compare_all();
    check("go_during_done", go_in_done, 0);

    // start pulsed during WAIT is ignored
    set_tbl(-2, -1, -1, -9);
    d0 = done_cnt;
    start_pass(1'b1, acc);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (10) @(negedge clk);
    check("pulse_done_count", done_cnt - d0, 1);
    check("pulse_idle_busy", busy, 0);
    compare_all();

    // reset during WAIT of neuron 2
    set_tbl(3, -7, 20, 5);
    start_pass(1'b0, acc);
    while (cyc < acc + 19) @(negedge clk);
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_results", results, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_go", neuron_go, 0);
    check("abort_argmax", argmax, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_busy", busy, 0);
    go_q.delete();
    obs_q.delete();
    run_pass();

    // back-to-back pass with a new table overwrites every slot
    set_tbl(0, 0, 127, -128);
    run_pass();
    check("overwrite_results_lit", results, 32'h807F0000);
    check("overwrite_argmax_lit", argmax, AM_EN ? 2 : 0);
    check("go_during_done_final", go_in_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
